hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage, 16-register core, and the producer side of the forwarding interface. Decoded fields from ID are carried through internal shadow ID/EX, EX/MEM and MEM/WB registers. These registers drive the stage-tagged Rd/Rt/RegWrite/MemWrite/MemToReg signals that the forwarding unit consumes. From the same state the block generates load-use and flag stalls, ID-branch flushes and memory-busy freezes, and keeps saturating hazard cycle counters.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: shadow ID/EX, EX/MEM and MEM/WB fields for forwarding,
// load-use / flag stalls, branch flush, memory-busy freeze and saturating hazard counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ID_Rs,
    input  logic [3:0]  ID_Rt,
    input  logic [3:0]  ID_Rd,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        ID_MemWrite,
    input  logic        ID_MemToReg,
    input  logic        ID_SetsFlags,
    input  logic        ID_IsBranch,
    input  logic        ID_BranchTaken,
    input  logic        Mem_Busy,
    output logic        PC_Stall,
    output logic        IFID_Stall,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        Freeze,
    output logic [3:0]  IDEX_Rs,
    output logic [3:0]  IDEX_Rt,
    output logic [3:0]  IDEX_Rd,
    output logic        IDEX_RegWrite,
    output logic        IDEX_MemRead,
    output logic        IDEX_SetsFlags,
    output logic [3:0]  EXMem_Rd,
    output logic [3:0]  EXMem_Rt,
    output logic        EXMem_RegWrite,
    output logic        EXMem_MemWrite,
    output logic [3:0]  MemWB_Rd,
    output logic        MemWB_RegWrite,
    output logic        MemWB_MemToReg,
    output logic [15:0] Stall_Cnt,
    output logic [15:0] Freeze_Cnt
);

    logic [3:0]  idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_rd_q, idex_rd_d;
    logic        idex_rw_q, idex_rw_d, idex_mr_q, idex_mr_d;
    logic        idex_mw_q, idex_mw_d, idex_sf_q, idex_sf_d;
    logic [3:0]  exm_rd_q, exm_rd_d, exm_rt_q, exm_rt_d;
    logic        exm_rw_q, exm_rw_d, exm_mw_q, exm_mw_d, exm_mr_q, exm_mr_d;
    logic [3:0]  mwb_rd_q, mwb_rd_d;
    logic        mwb_rw_q, mwb_rw_d, mwb_mtr_q, mwb_mtr_d;
    logic [15:0] stall_cnt_q, stall_cnt_d, freeze_cnt_q, freeze_cnt_d;
    logic        load_use, flag_haz, freeze, stall;

    // Write-back select is derived from MemRead as it travels down the pipe.
    logic unused_memtoreg;
    assign unused_memtoreg = ID_MemToReg;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        load_use = idex_mr_q && (idex_rd_q != 4'd0) &&
                   ((ID_UsesRs && (idex_rd_q == ID_Rs)) ||
                    (ID_UsesRt && (idex_rd_q == ID_Rt) && !ID_MemWrite));
        flag_haz = ID_IsBranch && idex_sf_q;
        freeze   = Mem_Busy;
        stall    = !freeze && (load_use || flag_haz);

        Freeze      = freeze;
        PC_Stall    = freeze || stall;
        IFID_Stall  = freeze || stall;
        IDEX_Bubble = stall;
        IFID_Flush  = !freeze && !stall && ID_BranchTaken;
    end

    always_comb begin
        idex_rs_d = idex_rs_q;  idex_rt_d = idex_rt_q;  idex_rd_d = idex_rd_q;
        idex_rw_d = idex_rw_q;  idex_mr_d = idex_mr_q;
        idex_mw_d = idex_mw_q;  idex_sf_d = idex_sf_q;
        exm_rd_d  = exm_rd_q;   exm_rt_d  = exm_rt_q;
        exm_rw_d  = exm_rw_q;   exm_mw_d  = exm_mw_q;   exm_mr_d = exm_mr_q;
        mwb_rd_d  = mwb_rd_q;   mwb_rw_d  = mwb_rw_q;   mwb_mtr_d = mwb_mtr_q;
        stall_cnt_d  = stall_cnt_q;
        freeze_cnt_d = freeze_cnt_q;

        if (freeze) begin
            freeze_cnt_d = sat_inc(freeze_cnt_q);
        end else begin
            if (stall) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
                idex_rs_d = 4'd0;  idex_rt_d = 4'd0;  idex_rd_d = 4'd0;
                idex_rw_d = 1'b0;  idex_mr_d = 1'b0;
                idex_mw_d = 1'b0;  idex_sf_d = 1'b0;
            end else begin
                idex_rs_d = ID_Rs;        idex_rt_d = ID_Rt;        idex_rd_d = ID_Rd;
                idex_rw_d = ID_RegWrite;  idex_mr_d = ID_MemRead;
                idex_mw_d = ID_MemWrite;  idex_sf_d = ID_SetsFlags;
            end
            exm_rd_d  = idex_rd_q;  exm_rt_d = idex_rt_q;
            exm_rw_d  = idex_rw_q;  exm_mw_d = idex_mw_q;  exm_mr_d = idex_mr_q;
            mwb_rd_d  = exm_rd_q;   mwb_rw_d = exm_rw_q;   mwb_mtr_d = exm_mr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_rs_q <= 4'd0;  idex_rt_q <= 4'd0;  idex_rd_q <= 4'd0;
            idex_rw_q <= 1'b0;  idex_mr_q <= 1'b0;  idex_mw_q <= 1'b0;  idex_sf_q <= 1'b0;
            exm_rd_q  <= 4'd0;  exm_rt_q  <= 4'd0;
            exm_rw_q  <= 1'b0;  exm_mw_q  <= 1'b0;  exm_mr_q  <= 1'b0;
            mwb_rd_q  <= 4'd0;  mwb_rw_q  <= 1'b0;  mwb_mtr_q <= 1'b0;
            stall_cnt_q  <= 16'd0;
            freeze_cnt_q <= 16'd0;
        end else begin
            idex_rs_q <= idex_rs_d;  idex_rt_q <= idex_rt_d;  idex_rd_q <= idex_rd_d;
            idex_rw_q <= idex_rw_d;  idex_mr_q <= idex_mr_d;
            idex_mw_q <= idex_mw_d;  idex_sf_q <= idex_sf_d;
            exm_rd_q  <= exm_rd_d;   exm_rt_q  <= exm_rt_d;
            exm_rw_q  <= exm_rw_d;   exm_mw_q  <= exm_mw_d;   exm_mr_q <= exm_mr_d;
            mwb_rd_q  <= mwb_rd_d;   mwb_rw_q  <= mwb_rw_d;   mwb_mtr_q <= mwb_mtr_d;
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign IDEX_Rs        = idex_rs_q;
    assign IDEX_Rt        = idex_rt_q;
    assign IDEX_Rd        = idex_rd_q;
    assign IDEX_RegWrite  = idex_rw_q;
    assign IDEX_MemRead   = idex_mr_q;
    assign IDEX_SetsFlags = idex_sf_q;
    assign EXMem_Rd       = exm_rd_q;
    assign EXMem_Rt       = exm_rt_q;
    assign EXMem_RegWrite = exm_rw_q;
    assign EXMem_MemWrite = exm_mw_q;
    assign MemWB_Rd       = mwb_rd_q;
    assign MemWB_RegWrite = mwb_rw_q;
    assign MemWB_MemToReg = mwb_mtr_q;
    assign Stall_Cnt      = stall_cnt_q;
    assign Freeze_Cnt     = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

    logic        clk, rst;
    logic [3:0]  ID_Rs, ID_Rt, ID_Rd;
    logic        ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_MemWrite;
    logic        ID_MemToReg, ID_SetsFlags, ID_IsBranch, ID_BranchTaken, Mem_Busy;
    logic        PC_Stall, IFID_Stall, IFID_Flush, IDEX_Bubble, Freeze;
    logic [3:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd, EXMem_Rd, EXMem_Rt, MemWB_Rd;
    logic        IDEX_RegWrite, IDEX_MemRead, IDEX_SetsFlags;
    logic        EXMem_RegWrite, EXMem_MemWrite, MemWB_RegWrite, MemWB_MemToReg;
    logic [15:0] Stall_Cnt, Freeze_Cnt;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemToReg(ID_MemToReg), .ID_SetsFlags(ID_SetsFlags),
        .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken), .Mem_Busy(Mem_Busy),
        .PC_Stall(PC_Stall), .IFID_Stall(IFID_Stall), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .Freeze(Freeze),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_SetsFlags(IDEX_SetsFlags),
        .EXMem_Rd(EXMem_Rd), .EXMem_Rt(EXMem_Rt),
        .EXMem_RegWrite(EXMem_RegWrite), .EXMem_MemWrite(EXMem_MemWrite),
        .MemWB_Rd(MemWB_Rd), .MemWB_RegWrite(MemWB_RegWrite), .MemWB_MemToReg(MemWB_MemToReg),
        .Stall_Cnt(Stall_Cnt), .Freeze_Cnt(Freeze_Cnt)
    );

    localparam int F_CTRL = 0, F_IDEX_RD = 1, F_IDEX_RW = 2, F_IDEX_MR = 3, F_IDEX_SF = 4;
    localparam int F_EXM_RD = 5, F_EXM_RT = 6, F_EXM_MW = 7, F_MWB_RD = 8, F_MWB_MTR = 9;
    localparam int F_SCNT = 10, F_FCNT = 11, F_SHADOW = 12;
    localparam logic [31:0] C_IDLE = 32'b00000, C_STALL = 32'b01110;
    localparam logic [31:0] C_FREEZE = 32'b11100, C_FLUSH = 32'b00001;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] act;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] sh(input logic [3:0] irs, irt, ird, input logic irw, imr, isf,
                                       input logic [3:0] erd, ert, input logic erw, emw,
                                       input logic [3:0] mrd, input logic mrw, mmtr);
        return {1'b0, irs, irt, ird, irw, imr, isf, erd, ert, erw, emw, mrd, mrw, mmtr};
    endfunction

    function automatic logic [31:0] get(input int f);
        case (f)
            F_CTRL:    return {27'd0, Freeze, PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush};
            F_IDEX_RD: return {28'd0, IDEX_Rd};
            F_IDEX_RW: return {31'd0, IDEX_RegWrite};
            F_IDEX_MR: return {31'd0, IDEX_MemRead};
            F_IDEX_SF: return {31'd0, IDEX_SetsFlags};
            F_EXM_RD:  return {28'd0, EXMem_Rd};
            F_EXM_RT:  return {28'd0, EXMem_Rt};
            F_EXM_MW:  return {31'd0, EXMem_MemWrite};
            F_MWB_RD:  return {28'd0, MemWB_Rd};
            F_MWB_MTR: return {31'd0, MemWB_MemToReg};
            F_SCNT:    return {16'd0, Stall_Cnt};
            F_FCNT:    return {16'd0, Freeze_Cnt};
            default:   return sh(IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_RegWrite, IDEX_MemRead,
                                 IDEX_SetsFlags, EXMem_Rd, EXMem_Rt, EXMem_RegWrite,
                                 EXMem_MemWrite, MemWB_Rd, MemWB_RegWrite, MemWB_MemToReg);
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = get(e.fld);
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic expect_f(input int f, input logic [31:0] v, input string n);
        exp_t x;
        x.cyc = cyc; x.fld = f; x.val = v; x.name = n;
        q.push_back(x);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] rs, rt, rd, input logic urs, urt,
                          input logic rw, mr, mw, sf, br, bt);
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRs = urs; ID_UsesRt = urt;
        ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = mw; ID_MemToReg = mr;
        ID_SetsFlags = sf; ID_IsBranch = br; ID_BranchTaken = bt;
    endtask

    task automatic flush_pipe();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) adv();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Mem_Busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); adv();
        expect_f(F_CTRL, C_IDLE, "reset_ctrl");
        expect_f(F_SHADOW, 32'd0, "reset_shadow");
        expect_f(F_SCNT, 32'd0, "reset_scnt");
        expect_f(F_FCNT, 32'd0, "reset_fcnt");
        rst = 1'b0;
        adv();

        // load-use on Rs: lw R3 then add R5,R3,R4
        set_id(1, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0);
        expect_f(F_CTRL, C_IDLE, "lu_before");
        adv();
        set_id(3, 4, 5, 1, 1, 1, 0, 0, 0, 0, 0);
        expect_f(F_CTRL, C_STALL, "lu_stall");
        expect_f(F_IDEX_RD, 32'd3, "lu_idex_rd_load");
        expect_f(F_IDEX_MR, 32'd1, "lu_idex_mr_load");
        adv();
        expect_f(F_CTRL, C_IDLE, "lu_released");
        expect_f(F_IDEX_RW, 32'd0, "lu_bubble_rw");
        expect_f(F_IDEX_RD, 32'd0, "lu_bubble_rd");
        expect_f(F_EXM_RD, 32'd3, "lu_exm_rd");
        expect_f(F_SCNT, 32'd1, "lu_scnt");
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_f(F_IDEX_RD, 32'd5, "lu_add_idex_rd");
        expect_f(F_IDEX_RW, 32'd1, "lu_add_idex_rw");
        expect_f(F_EXM_RD, 32'd0, "lu_bubble_exm");
        expect_f(F_MWB_RD, 32'd3, "lu_mwb_rd");
        expect_f(F_MWB_MTR, 32'd1, "lu_mwb_mtr");
        expect_f(F_SCNT, 32'd1, "lu_scnt_hold");
        flush_pipe();

        // load then store of the loaded register as data
        set_id(1, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0);
        adv();
        set_id(2, 3, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        expect_f(F_CTRL, C_IDLE, "st_no_stall");
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_f(F_EXM_RD, 32'd3, "st_exm_rd_load");
        adv();
        expect_f(F_EXM_MW, 32'd1, "st_exm_mw");
        expect_f(F_EXM_RT, 32'd3, "st_exm_rt");
        expect_f(F_MWB_RD, 32'd3, "st_mwb_rd");
        expect_f(F_MWB_MTR, 32'd1, "st_mwb_mtr");
        flush_pipe();

        // load to R0 followed by a reader of R0
        set_id(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        adv();
        set_id(0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 0);
        expect_f(F_CTRL, C_IDLE, "r0_no_stall");
        expect_f(F_IDEX_MR, 32'd1, "r0_idex_mr");
        adv();
        expect_f(F_IDEX_RD, 32'd9, "r0_advanced");
        flush_pipe();

        // flag hazard with a taken branch, then the branch re-resolves
        set_id(1, 2, 6, 1, 1, 1, 0, 0, 1, 0, 0);
        expect_f(F_CTRL, C_IDLE, "fl_before");
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        expect_f(F_CTRL, C_STALL, "fl_stall_no_flush");
        expect_f(F_IDEX_SF, 32'd1, "fl_idex_sf");
        adv();
        expect_f(F_CTRL, C_FLUSH, "fl_flush");
        expect_f(F_SCNT, 32'd2, "fl_scnt");
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_f(F_CTRL, C_IDLE, "fl_after");
        flush_pipe();

        // memory freeze over a pending load-use
        set_id(1, 0, 7, 1, 0, 1, 1, 0, 0, 0, 0);
        adv();
        set_id(7, 2, 8, 1, 1, 1, 0, 0, 0, 0, 0);
        Mem_Busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_f(F_CTRL, C_FREEZE, "fz_ctrl");
            expect_f(F_SHADOW, sh(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "fz_shadow_hold");
            expect_f(F_FCNT, i, "fz_fcnt");
            adv();
        end
        Mem_Busy = 1'b0;
        expect_f(F_CTRL, C_STALL, "fz_then_stall");
        expect_f(F_SHADOW, sh(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "fz_shadow_after");
        expect_f(F_FCNT, 32'd3, "fz_fcnt_total");
        expect_f(F_SCNT, 32'd2, "fz_scnt_unchanged");
        adv();
        expect_f(F_CTRL, C_IDLE, "fz_stall_done");
        expect_f(F_IDEX_RD, 32'd0, "fz_bubble_rd");
        expect_f(F_EXM_RD, 32'd7, "fz_exm_rd");
        expect_f(F_SCNT, 32'd3, "fz_scnt");
        flush_pipe();

        // reset asserted mid-stall, then with Mem_Busy high
        set_id(1, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0);
        adv();
        set_id(3, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        expect_f(F_CTRL, C_STALL, "rs_stall_pending");
        adv();
        Mem_Busy = 1'b1;
        expect_f(F_CTRL, C_FREEZE, "rs_freeze_in_reset");
        expect_f(F_SHADOW, 32'd0, "rs_shadow_clear");
        expect_f(F_SCNT, 32'd0, "rs_scnt_clear");
        expect_f(F_FCNT, 32'd0, "rs_fcnt_clear");
        adv();
        rst = 1'b0;
        Mem_Busy = 1'b0;
        expect_f(F_CTRL, C_IDLE, "rs_ctrl_after");
        expect_f(F_SHADOW, 32'd0, "rs_shadow_after");
        expect_f(F_FCNT, 32'd0, "rs_fcnt_after");
        flush_pipe();

        // freeze counter saturation
        Mem_Busy = 1'b1;
        repeat (65534) adv();
        expect_f(F_FCNT, 32'hFFFE, "sat_fcnt_below");
        adv();
        expect_f(F_FCNT, 32'hFFFF, "sat_fcnt_top");
        adv(); adv();
        expect_f(F_FCNT, 32'hFFFF, "sat_fcnt_hold");
        expect_f(F_SCNT, 32'd0, "sat_scnt_idle");
        Mem_Busy = 1'b0;
        adv();
        expect_f(F_FCNT, 32'hFFFF, "sat_fcnt_release");
        repeat (3) adv();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, 0 required", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
